ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Control stage directly downstream of instr_rom: consumes the 9-bit instruction word and drives every control input of reg_file, data_ram, ALU and the fetch unit.
- Adds the run-control FSM: start handshake, two-cycle load stall, halt and done.
- Adds a retired-instruction counter used for debug and verification.

Parameters:
- IW, 9, instruction width; only 9 is supported.
- CW, 16, retired-instruction counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- instruction  in  9  current word from instr_rom; valid for the whole cycle.
- equalFlag  in  1  registered ALU flag.
- lessThanFlag  in  1  registered ALU flag.
- fetch_start  out  1  one-cycle pulse to the fetch Start input; loads the PC from Start_Address.
- stall  out  1  fetch must hold the PC this cycle.
- Halt  out  1  fetch halt.
- branch  out  1  branch instruction present.
- branchCond  out  1  branch taken (flag test passed).
- REGWRITE, SETSRC, SETDEST, MOV  out  1 each  reg_file controls.
- MemRead, MemWrite  out  1 each  data_ram controls.
- ALUop  out  3  ALU operation.
- rt_index  out  3  register index.
- LUT_MEM_INDEX  out  6  address LUT index.
- LUT_CONST_INDEX  out  3  constant/offset LUT index.
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 constant, 3 reserved.
- retired  out  CW  count of completed instructions.
- done  out  1  high while HALTED.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, retired=0. All outputs 0 except Halt=1.
- Releasing reset takes effect on the next CLK edge.
- Asserting reset mid-operation, including mid-load, aborts immediately with no memory write.
- IDLE:
  - Halt=1; all controls 0.
  - start=1 -> RUN. fetch_start=1 in that same IDLE cycle.
- Decode (RUN and LOAD_WAIT only; every control output is 0 in other states), op = instruction[8:6]:
  - 000 ALU: ALUop=i[5:3], rt_index=i[2:0], REGWRITE=1, wb_sel=0.
  - 001 register-move group, rt_index=i[2:0], selected by i[5:4]:
    - 00 SETSRC.
    - 01 SETDEST.
    - 10 MOV.
    - 11 NOP.
  - 010 LOAD: LUT_MEM_INDEX=i[5:0], MemRead=1, wb_sel=1.
  - 011 STORE: LUT_MEM_INDEX=i[5:0], MemWrite=1 for exactly one cycle.
  - 100 BEQ: branch=1, LUT_CONST_INDEX=i[2:0], branchCond=equalFlag.
  - 101 BLT: branch=1, LUT_CONST_INDEX=i[2:0], branchCond=lessThanFlag.
  - 110 LOADI: LUT_CONST_INDEX=i[2:0], REGWRITE=1, wb_sel=2.
  - 111 with i[5:0]=6'h3F: HALT -> HALTED. Any other 111 word is a NOP.
- LOAD timing:
  - Cycle 1 (RUN): MemRead=1, stall=1, REGWRITE=0 -> LOAD_WAIT.
  - Cycle 2 (LOAD_WAIT): MemRead=1, REGWRITE=1, stall=0 -> RUN.
  - Total 2 cycles. Every other instruction takes 1 cycle; stall=0.
- retired:
  - Increments on the final cycle of every instruction, including NOPs, branches and HALT.
  - Does not increment on LOAD cycle 1.
  - Saturates at all-ones; no wrap.
- HALTED:
  - Halt=1, done=1, all controls 0.
  - start=1 -> IDLE (done drops next cycle). retired is held; it clears only on reset.
- start in RUN, LOAD_WAIT or HALTED-without-restart is ignored.
- Flags are read in the same cycle as the branch word. Back-to-back ALU then branch must use the flags that were registered at the preceding edge.

Test Plan:
- Reset, then start pulse -> fetch_start=1 for exactly 1 cycle. Next cycle in RUN. Halt=0, retired=0.
- Words 9'b000_011_101, 9'b110_000_010 -> cycle 1: REGWRITE=1, ALUop=3, rt_index=5, wb_sel=0. Cycle 2: LUT_CONST_INDEX=2, wb_sel=2. retired=2.
- LOAD 9'b010_101010 -> cycle 1: MemRead=1, stall=1, REGWRITE=0. Cycle 2: REGWRITE=1, wb_sel=1, stall=0, LUT_MEM_INDEX=42. retired increments once.
- BEQ 9'b100_000_011 with equalFlag=1 -> branch=1, branchCond=1, LUT_CONST_INDEX=3. Repeat with equalFlag=0 -> branchCond=0. BLT with lessThanFlag=1 -> branchCond=1.
- HALT 9'h1FF -> done=1, Halt=1 the next cycle, retired frozen. Then start=1 -> IDLE, done=0.
- Reset asserted during LOAD_WAIT with an asynchronous edge -> outputs 0 and Halt=1 immediately, no MemWrite, retired=0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Control stage behind instr_rom: decodes the 9-bit instruction word into reg_file/data_ram/ALU/fetch
// controls, runs the start/load-stall/halt FSM and keeps a saturating retired-instruction counter.
module ctrl_sequencer #(
   parameter int IW = 9,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          start,
   input  logic [IW-1:0] instruction,
   input  logic          equalFlag,
   input  logic          lessThanFlag,
   output logic          fetch_start,
   output logic          stall,
   output logic          Halt,
   output logic          branch,
   output logic          branchCond,
   output logic          REGWRITE,
   output logic          SETSRC,
   output logic          SETDEST,
   output logic          MOV,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [2:0]    ALUop,
   output logic [2:0]    rt_index,
   output logic [5:0]    LUT_MEM_INDEX,
   output logic [2:0]    LUT_CONST_INDEX,
   output logic [1:0]    wb_sel,
   output logic [CW-1:0] retired,
   output logic          done
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_LOAD_WAIT = 2'd2;
   localparam logic [1:0] ST_HALTED    = 2'd3;

   localparam logic [2:0] OP_ALU   = 3'b000;
   localparam logic [2:0] OP_MOVE  = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_BEQ   = 3'b100;
   localparam logic [2:0] OP_BLT   = 3'b101;
   localparam logic [2:0] OP_LOADI = 3'b110;
   localparam logic [2:0] OP_SYS   = 3'b111;

   localparam logic [1:0] WB_ALU   = 2'd0;
   localparam logic [1:0] WB_MEM   = 2'd1;
   localparam logic [1:0] WB_CONST = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic          retire;
   logic [5:0]    load_index;
   logic [2:0]    op;

   assign op = instruction[8:6];

   // NOTE: every output and next_state gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      next_state      = state;
      retire          = 1'b0;
      fetch_start     = 1'b0;
      stall           = 1'b0;
      Halt            = 1'b0;
      branch          = 1'b0;
      branchCond      = 1'b0;
      REGWRITE        = 1'b0;
      SETSRC          = 1'b0;
      SETDEST         = 1'b0;
      MOV             = 1'b0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      ALUop           = 3'd0;
      rt_index        = 3'd0;
      LUT_MEM_INDEX   = 6'd0;
      LUT_CONST_INDEX = 3'd0;
      wb_sel          = WB_ALU;
      done            = 1'b0;

      case (state)
         ST_IDLE: begin
            Halt = 1'b1;
            if (start) begin
               // Gated by reset so a held start cannot pulse fetch while reset is asserted.
               fetch_start = reset;
               next_state  = ST_RUN;
            end
         end

         ST_RUN: begin
            retire = 1'b1;
            case (op)
               OP_ALU: begin
                  ALUop    = instruction[5:3];
                  rt_index = instruction[2:0];
                  REGWRITE = 1'b1;
                  wb_sel   = WB_ALU;
               end
               OP_MOVE: begin
                  rt_index = instruction[2:0];
                  case (instruction[5:4])
                     2'b00:   SETSRC  = 1'b1;
                     2'b01:   SETDEST = 1'b1;
                     2'b10:   MOV     = 1'b1;
                     default: ;
                  endcase
               end
               OP_LOAD: begin
                  // First load cycle: hold fetch and let the RAM read settle before write-back.
                  LUT_MEM_INDEX = instruction[5:0];
                  MemRead       = 1'b1;
                  wb_sel        = WB_MEM;
                  stall         = 1'b1;
                  retire        = 1'b0;
                  next_state    = ST_LOAD_WAIT;
               end
               OP_STORE: begin
                  LUT_MEM_INDEX = instruction[5:0];
                  MemWrite      = 1'b1;
               end
               OP_BEQ: begin
                  branch          = 1'b1;
                  LUT_CONST_INDEX = instruction[2:0];
                  branchCond      = equalFlag;
               end
               OP_BLT: begin
                  branch          = 1'b1;
                  LUT_CONST_INDEX = instruction[2:0];
                  branchCond      = lessThanFlag;
               end
               OP_LOADI: begin
                  LUT_CONST_INDEX = instruction[2:0];
                  REGWRITE        = 1'b1;
                  wb_sel          = WB_CONST;
               end
               OP_SYS: begin
                  if (instruction[5:0] == 6'h3F) next_state = ST_HALTED;
               end
               default: ;
            endcase
         end

         ST_LOAD_WAIT: begin
            LUT_MEM_INDEX = load_index;
            MemRead       = 1'b1;
            REGWRITE      = 1'b1;
            wb_sel        = WB_MEM;
            retire        = 1'b1;
            next_state    = ST_RUN;
         end

         ST_HALTED: begin
            Halt = 1'b1;
            done = 1'b1;
            if (start) next_state = ST_IDLE;
         end

         default: begin
            Halt       = 1'b1;
            next_state = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         retired    <= '0;
         load_index <= 6'd0;
      end else begin
         state <= next_state;
         if (retire && (retired != {CW{1'b1}})) retired <= retired + CW'(1);
         // The address is kept so the second load cycle does not depend on the word still being presented.
         if (state == ST_RUN && op == OP_LOAD) load_index <= instruction[5:0];
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: hand-computed vectors over run control, decode, load stall,
// halt/restart, asynchronous abort mid-load and counter saturation.
module tb_ctrl_sequencer;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start;
   logic [8:0]  instruction;
   logic        equalFlag;
   logic        lessThanFlag;
   logic        fetch_start, stall, Halt, branch, branchCond;
   logic        REGWRITE, SETSRC, SETDEST, MOV, MemRead, MemWrite;
   logic [2:0]  ALUop, rt_index, LUT_CONST_INDEX;
   logic [5:0]  LUT_MEM_INDEX;
   logic [1:0]  wb_sel;
   logic [15:0] retired;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   ctrl_sequencer #(.IW(9), .CW(16)) dut (
      .CLK(CLK), .reset(reset), .start(start), .instruction(instruction),
      .equalFlag(equalFlag), .lessThanFlag(lessThanFlag),
      .fetch_start(fetch_start), .stall(stall), .Halt(Halt), .branch(branch),
      .branchCond(branchCond), .REGWRITE(REGWRITE), .SETSRC(SETSRC), .SETDEST(SETDEST),
      .MOV(MOV), .MemRead(MemRead), .MemWrite(MemWrite), .ALUop(ALUop),
      .rt_index(rt_index), .LUT_MEM_INDEX(LUT_MEM_INDEX), .LUT_CONST_INDEX(LUT_CONST_INDEX),
      .wb_sel(wb_sel), .retired(retired), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; instruction = 9'd0; equalFlag = 1'b0; lessThanFlag = 1'b0;
      #3;
      check("rst_halt", 32'(Halt), 1);
      check("rst_retired", 32'(retired), 0);
      check("rst_done", 32'(done), 0);
      check("rst_regwrite", 32'(REGWRITE), 0);
      tick();
      reset = 1'b1;
      tick();
      #1;
      check("idle_halt", 32'(Halt), 1);
      check("idle_fetch_start", 32'(fetch_start), 0);

      // start handshake
      start = 1'b1;
      #1;
      check("start_fetch_start", 32'(fetch_start), 1);
      tick();
      start = 1'b0;
      instruction = 9'b000_011_101;
      #1;
      check("run_fetch_start", 32'(fetch_start), 0);
      check("run_halt", 32'(Halt), 0);
      check("run_retired0", 32'(retired), 0);
      check("alu_regwrite", 32'(REGWRITE), 1);
      check("alu_aluop", 32'(ALUop), 3);
      check("alu_rt", 32'(rt_index), 5);
      check("alu_wbsel", 32'(wb_sel), 0);
      check("alu_stall", 32'(stall), 0);

      tick();
      instruction = 9'b110_000_010;
      #1;
      check("loadi_const", 32'(LUT_CONST_INDEX), 2);
      check("loadi_wbsel", 32'(wb_sel), 2);
      check("loadi_regwrite", 32'(REGWRITE), 1);
      check("loadi_retired", 32'(retired), 1);

      // two-cycle load; instruction held while stalled
      tick();
      instruction = 9'b010_101010;
      #1;
      check("ld1_retired", 32'(retired), 2);
      check("ld1_memread", 32'(MemRead), 1);
      check("ld1_stall", 32'(stall), 1);
      check("ld1_regwrite", 32'(REGWRITE), 0);
      check("ld1_index", 32'(LUT_MEM_INDEX), 42);
      tick();
      #1;
      check("ld2_memread", 32'(MemRead), 1);
      check("ld2_regwrite", 32'(REGWRITE), 1);
      check("ld2_wbsel", 32'(wb_sel), 1);
      check("ld2_stall", 32'(stall), 0);
      check("ld2_index", 32'(LUT_MEM_INDEX), 42);
      check("ld2_retired", 32'(retired), 2);

      tick();
      instruction = 9'b011_000111;
      start = 1'b1;
      #1;
      check("ld_done_retired", 32'(retired), 3);
      check("st_memwrite", 32'(MemWrite), 1);
      check("st_index", 32'(LUT_MEM_INDEX), 7);
      check("st_regwrite", 32'(REGWRITE), 0);
      check("run_start_ignored", 32'(fetch_start), 0);

      tick();
      start = 1'b0;
      instruction = 9'b100_000_011;
      equalFlag = 1'b1;
      #1;
      check("st_once", 32'(MemWrite), 0);
      check("beq1_branch", 32'(branch), 1);
      check("beq1_cond", 32'(branchCond), 1);
      check("beq1_const", 32'(LUT_CONST_INDEX), 3);

      tick();
      equalFlag = 1'b0;
      lessThanFlag = 1'b1;
      #1;
      check("beq0_cond", 32'(branchCond), 0);

      tick();
      instruction = 9'b101_000_001;
      equalFlag = 1'b0;
      lessThanFlag = 1'b1;
      #1;
      check("blt1_branch", 32'(branch), 1);
      check("blt1_cond", 32'(branchCond), 1);
      check("blt1_const", 32'(LUT_CONST_INDEX), 1);

      tick();
      instruction = 9'b001_010_110;
      lessThanFlag = 1'b0;
      #1;
      check("setdest", 32'(SETDEST), 1);
      check("setdest_src", 32'(SETSRC), 0);
      check("setdest_rt", 32'(rt_index), 6);
      check("setdest_branch", 32'(branch), 0);

      tick();
      instruction = 9'b111_000_000;
      #1;
      check("nop111_halt", 32'(Halt), 0);
      check("nop111_regwrite", 32'(REGWRITE), 0);
      check("nop111_retired", 32'(retired), 8);

      // halt and restart
      tick();
      instruction = 9'h1FF;
      #1;
      check("haltword_done", 32'(done), 0);
      check("haltword_retired", 32'(retired), 9);
      tick();
      instruction = 9'b000_001_001;
      #1;
      check("halted_done", 32'(done), 1);
      check("halted_halt", 32'(Halt), 1);
      check("halted_retired", 32'(retired), 10);
      check("halted_regwrite", 32'(REGWRITE), 0);
      tick();
      start = 1'b1;
      #1;
      check("halted_frozen", 32'(retired), 10);
      check("halted_no_fetch", 32'(fetch_start), 0);
      tick();
      start = 1'b0;
      #1;
      check("restart_done", 32'(done), 0);
      check("restart_halt", 32'(Halt), 1);
      check("restart_retired", 32'(retired), 10);

      // asynchronous reset while in the second load cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      instruction = 9'b010_000101;
      #1;
      check("ld_abort_stall", 32'(stall), 1);
      tick();
      #1;
      check("ld_abort_wait_memread", 32'(MemRead), 1);
      reset = 1'b0;
      #1;
      check("abort_halt", 32'(Halt), 1);
      check("abort_memread", 32'(MemRead), 0);
      check("abort_regwrite", 32'(REGWRITE), 0);
      check("abort_memwrite", 32'(MemWrite), 0);
      check("abort_retired", 32'(retired), 0);
      tick();
      reset = 1'b1;
      tick();

      // counter saturation
      start = 1'b1;
      tick();
      start = 1'b0;
      instruction = 9'b001_110_000;
      #1;
      check("sat_start", 32'(retired), 0);
      repeat (65534) tick();
      check("sat_near", 32'(retired), 32'hFFFE);
      repeat (5) tick();
      check("sat_hold", 32'(retired), 32'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
